// File: rtl/lms_pkg.sv
// Shared types for the LMS sample sequencer: data width, FSM states, sample pair.
package lms_pkg;
    localparam int LMS_DW = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        logic [LMS_DW-1:0] x;
        logic [LMS_DW-1:0] d;
    } lms_pair_t;
endpackage

// File: rtl/lms_stream_seq_if.sv
// Sample-in / result-out streams of the sequencer; slave is the sequencer side.
interface lms_stream_seq_if;
    import lms_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [LMS_DW-1:0] s_x;
    logic [LMS_DW-1:0] s_d;
    logic              m_valid;
    logic              m_ready;
    logic [LMS_DW-1:0] m_y;
    logic [LMS_DW-1:0] m_err;

    modport master (
        output s_valid, s_x, s_d, m_ready,
        input  s_ready, m_valid, m_y, m_err
    );

    modport slave (
        input  s_valid, s_x, s_d, m_ready,
        output s_ready, m_valid, m_y, m_err
    );
endinterface

// File: rtl/lms_sample_fifo.sv
// Synchronous FIFO of (x, d) pairs; no write-to-read bypass.
module lms_sample_fifo
    import lms_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic      Clk,
    input  logic      Rst,
    input  logic      push,
    input  lms_pair_t din,
    input  logic      pop,
    output lms_pair_t dout,
    output logic [AW:0] level,
    output logic      full,
    output logic      empty
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    lms_pair_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/lms_stream_seq.sv
// Paces buffered (x, d) pairs into the LMS core one at a time and returns
// each y/err through a single-entry valid/ready register.
module lms_stream_seq
    import lms_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CORE_LAT   = 2,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [LMS_DW-1:0] cfg_num,
    lms_stream_seq_if.slave   bus,
    output logic [LMS_DW-1:0] core_x,
    output logic [LMS_DW-1:0] core_d,
    output logic              core_strobe,
    input  logic [LMS_DW-1:0] core_y,
    input  logic [LMS_DW-1:0] core_err,
    output logic              busy,
    output logic              done_irq,
    output logic [LMS_DW-1:0] done_cnt,
    output logic [LW-1:0]     fifo_level
);
    localparam int CW = $clog2(CORE_LAT + 1);

    seq_state_e        state_q, state_d;
    lms_pair_t         fifo_dout;
    lms_pair_t         fifo_din;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              cap;
    logic              start_run;
    logic [CW-1:0]     cnt_q;
    logic [LMS_DW-1:0] num_q;
    logic              m_valid_q;
    logic [LMS_DW-1:0] m_y_q;
    logic [LMS_DW-1:0] m_err_q;

    assign fifo_din = '{x: bus.s_x, d: bus.s_d};

    lms_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (bus.s_valid),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.s_ready = !fifo_full;
    assign bus.m_valid = m_valid_q;
    assign bus.m_y     = m_y_q;
    assign bus.m_err   = m_err_q;
    assign busy        = (state_q != ST_IDLE);

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        cap       = 1'b0;
        start_run = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    if (cfg_num == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_LOAD;
                        start_run = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CW'(1)) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Core inputs are held, so y/err stay valid while we stall here.
                if (!m_valid_q || bus.m_ready) begin
                    cap     = 1'b1;
                    state_d = (LMS_DW'(done_cnt + 1'b1) == num_q) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over everything: no pop, no capture, no run start.
        if (cfg_abort) begin
            state_d   = ST_IDLE;
            pop       = 1'b0;
            cap       = 1'b0;
            start_run = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            core_x      <= '0;
            core_d      <= '0;
            core_strobe <= 1'b0;
            cnt_q       <= '0;
            num_q       <= '0;
            done_cnt    <= '0;
            done_irq    <= 1'b0;
            m_valid_q   <= 1'b0;
            m_y_q       <= '0;
            m_err_q     <= '0;
        end else begin
            core_strobe <= pop;
            done_irq    <= (state_q == ST_DONE) && !cfg_abort;
            if (pop) begin
                core_x <= fifo_dout.x;
                core_d <= fifo_dout.d;
                cnt_q  <= CW'(CORE_LAT);
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (start_run) begin
                num_q    <= cfg_num;
                done_cnt <= '0;
            end
            if (cap) begin
                m_y_q     <= core_y;
                m_err_q   <= core_err;
                m_valid_q <= 1'b1;
                done_cnt  <= done_cnt + 1'b1;
            end else if (bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lms_stream_seq.sv
// Directed bench for lms_stream_seq with a 2-stage stand-in core (y=x+d, err=d-x).
module tb_lms_stream_seq;
    import lms_pkg::*;

    localparam int FIFO_DEPTH = 16;
    localparam int CORE_LAT   = 2;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [15:0] cfg_num = '0;
    logic [15:0] core_x, core_d, core_y, core_err, done_cnt;
    logic        core_strobe, busy, done_irq;
    logic [LW-1:0] fifo_level;

    lms_stream_seq_if bus();

    lms_stream_seq #(.FIFO_DEPTH(FIFO_DEPTH), .CORE_LAT(CORE_LAT)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .cfg_start   (cfg_start),
        .cfg_abort   (cfg_abort),
        .cfg_num     (cfg_num),
        .bus         (bus),
        .core_x      (core_x),
        .core_d      (core_d),
        .core_strobe (core_strobe),
        .core_y      (core_y),
        .core_err    (core_err),
        .busy        (busy),
        .done_irq    (done_irq),
        .done_cnt    (done_cnt),
        .fifo_level  (fifo_level)
    );

    always #5 Clk = ~Clk;

    // Stand-in core: result appears CORE_LAT cycles after the inputs change.
    logic [15:0] py0 = '0, py1 = '0, pe0 = '0, pe1 = '0;
    always @(posedge Clk) begin
        py0 <= core_x + core_d;
        pe0 <= core_d - core_x;
        py1 <= py0;
        pe1 <= pe0;
    end
    assign core_y   = py1;
    assign core_err = pe1;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int          strobe_q[$];
    logic [31:0] res_q[$];
    int          irq_cnt = 0;
    always @(negedge Clk) begin
        if (core_strobe) strobe_q.push_back(cyc);
        if (bus.m_valid && bus.m_ready) res_q.push_back({bus.m_y, bus.m_err});
        if (done_irq) irq_cnt++;
    end

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] x, input logic [15:0] d);
        bus.s_valid = 1'b1;
        bus.s_x     = x;
        bus.s_d     = d;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic start(input logic [15:0] n);
        cfg_num   = n;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic clr();
        strobe_q.delete();
        res_q.delete();
        irq_cnt = 0;
    endtask

    function automatic logic [31:0] exp_res(input logic [15:0] x, input logic [15:0] d);
        logic [15:0] y, e;
        y = x + d;
        e = d - x;
        return {y, e};
    endfunction

    initial begin
        int t0;
        bus.s_valid = 1'b0;
        bus.s_x     = '0;
        bus.s_d     = '0;
        bus.m_ready = 1'b1;

        // Reset state
        tick(3);
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(core_strobe), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_core_x", 32'(core_x), 32'd0);
        Rst = 1'b0;
        tick();

        // Three-sample run, consumer always ready
        clr();
        push(16'h0100, 16'h0200);
        push(16'h0101, 16'h0201);
        push(16'h0102, 16'h0202);
        check("t1_level", 32'(fifo_level), 32'd3);
        t0 = cyc;
        start(16'd3);
        tick(20);
        check("t1_nstrobe", 32'(strobe_q.size()), 32'd3);
        check("t1_strobe0", 32'(strobe_q[0]), 32'(t0 + 2));
        check("t1_strobe1", 32'(strobe_q[1]), 32'(t0 + 6));
        check("t1_strobe2", 32'(strobe_q[2]), 32'(t0 + 10));
        check("t1_nres", 32'(res_q.size()), 32'd3);
        check("t1_res0", res_q[0], 32'h0300_0100);
        check("t1_res1", res_q[1], 32'h0302_0100);
        check("t1_res2", res_q[2], 32'h0304_0100);
        check("t1_done_cnt", 32'(done_cnt), 32'd3);
        check("t1_irq", 32'(irq_cnt), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);

        // Zero-length run
        clr();
        t0 = cyc;
        start(16'd0);
        check("t2_busy_c1", 32'(busy), 32'd1);
        check("t2_irq_c1", 32'(done_irq), 32'd0);
        tick();
        check("t2_irq_c2", 32'(done_irq), 32'd1);
        check("t2_busy_c2", 32'(busy), 32'd0);
        tick(3);
        check("t2_irq_cnt", 32'(irq_cnt), 32'd1);
        check("t2_nstrobe", 32'(strobe_q.size()), 32'd0);

        // Back-pressure stall in CAPTURE
        clr();
        bus.m_ready = 1'b0;
        push(16'h1000, 16'h0010);
        push(16'h2000, 16'h0020);
        t0 = cyc;
        start(16'd2);
        tick(14);
        check("t3_m_valid", 32'(bus.m_valid), 32'd1);
        check("t3_m_y_held", 32'(bus.m_y), 32'h1010);
        check("t3_m_err_held", 32'(bus.m_err), 32'hF010);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_done_cnt_stall", 32'(done_cnt), 32'd1);
        check("t3_nstrobe", 32'(strobe_q.size()), 32'd2);
        check("t3_irq_stall", 32'(irq_cnt), 32'd0);
        bus.m_ready = 1'b1;
        tick(6);
        check("t3_nres", 32'(res_q.size()), 32'd2);
        check("t3_res0", res_q[0], 32'h1010_F010);
        check("t3_res1", res_q[1], 32'h2020_E020);
        check("t3_irq", 32'(irq_cnt), 32'd1);
        check("t3_done_cnt", 32'(done_cnt), 32'd2);
        check("t3_m_valid_clr", 32'(bus.m_valid), 32'd0);

        // Full FIFO, dropped 17th push, 16-sample run in order
        clr();
        for (int i = 0; i < 16; i++) push(16'h4000 + 16'(i), 16'(i * 3));
        check("t4_s_ready", 32'(bus.s_ready), 32'd0);
        check("t4_level", 32'(fifo_level), 32'd16);
        push(16'hDEAD, 16'hBEEF);
        check("t4_level_drop", 32'(fifo_level), 32'd16);
        start(16'd16);
        tick(80);
        check("t4_nres", 32'(res_q.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("t4_res%0d", i), res_q[i], exp_res(16'h4000 + 16'(i), 16'(i * 3)));
        check("t4_level_end", 32'(fifo_level), 32'd0);
        check("t4_done_cnt", 32'(done_cnt), 32'd16);
        check("t4_irq", 32'(irq_cnt), 32'd1);

        // Empty FIFO at start: hold in LOAD until data arrives
        clr();
        t0 = cyc;
        start(16'd2);
        tick(9);
        check("t5_busy_wait", 32'(busy), 32'd1);
        check("t5_nstrobe_wait", 32'(strobe_q.size()), 32'd0);
        push(16'h0005, 16'h0007);
        push(16'h0009, 16'h0003);
        tick(20);
        check("t5_strobe0", 32'(strobe_q[0]), 32'(t0 + 12));
        check("t5_strobe1", 32'(strobe_q[1]), 32'(t0 + 16));
        check("t5_res0", res_q[0], 32'h000C_0002);
        check("t5_res1", res_q[1], 32'h000C_FFFA);
        check("t5_irq", 32'(irq_cnt), 32'd1);

        // Abort in WAIT of sample 2 of 5
        clr();
        for (int i = 0; i < 5; i++) push(16'h0A00 + 16'(i), 16'h0001);
        t0 = cyc;
        start(16'd5);
        tick(5);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done_cnt", 32'(done_cnt), 32'd1);
        check("t6_level", 32'(fifo_level), 32'd3);
        tick(10);
        check("t6_irq", 32'(irq_cnt), 32'd0);
        check("t6_nstrobe", 32'(strobe_q.size()), 32'd2);
        check("t6_nres", 32'(res_q.size()), 32'd1);
        check("t6_level_end", 32'(fifo_level), 32'd3);

        // Reset in the middle of a run
        start(16'd2);
        tick(3);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("t7_level", 32'(fifo_level), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_done_cnt", 32'(done_cnt), 32'd0);
        check("t7_m_valid", 32'(bus.m_valid), 32'd0);
        check("t7_s_ready", 32'(bus.s_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
